// File: rtl/fp_normalize_round_pack.sv
// fp_normalize_round_pack
//
// Back-end stage of the binary64 adder. Takes the unpacked, unrounded sum
// (sign, 13-bit two's-complement unbiased exponent, 57-bit extended mantissa),
// normalizes one shift per cycle, rounds to nearest-even and packs a binary64
// word. A single operand is in flight at a time.
//
// Ports:
//   clk_i                   rising-edge clock
//   rst_ni                  synchronous active-low reset
//   in_store_bit_i          upstream holds a valid operand
//   in_acknowledgment_o     block ready to accept an operand
//   in_sign_i               sign of the unrounded sum
//   in_exponent_i           unbiased exponent, two's complement
//   in_mantissa_i           [56] carry, [55] hidden, [54:3] fraction,
//                           [2] guard, [1] round, [0] sticky
//   result_store_bit_o      result valid
//   result_acknowledgment_i downstream accepts the result
//   result_o                packed binary64 result

module fp_normalize_round_pack (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_store_bit_i,
    output logic        in_acknowledgment_o,
    input  logic        in_sign_i,
    input  logic [12:0] in_exponent_i,
    input  logic [56:0] in_mantissa_i,
    output logic        result_store_bit_o,
    input  logic        result_acknowledgment_i,
    output logic [63:0] result_o
);

    localparam logic signed [12:0] ExpMin = -13'sd1022;
    localparam logic signed [12:0] ExpMax = 13'sd1023;

    typedef enum logic [2:0] {
        StIdle,
        StNormalize,
        StRound,
        StPack,
        StOutput
    } state_e;

    state_e             state_q, state_d;
    logic               sign_q, sign_d;
    logic signed [12:0] exp_q, exp_d;
    logic        [56:0] mant_q, mant_d;
    logic               zero_q, zero_d;
    logic               ack_q, ack_d;
    logic        [63:0] result_q, result_d;

    logic        [53:0] rounded;
    logic               round_up;
    logic        [10:0] biased_exp;

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        mant_d     = mant_q;
        zero_d     = zero_q;
        result_d   = result_q;
        ack_d      = 1'b0;
        round_up   = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
        rounded    = {1'b0, mant_q[55:3]} + 54'd1;
        // Low 11 bits of exp + 1023; upper bits are irrelevant to the packed field.
        biased_exp = exp_q[10:0] + 11'd1023;

        case (state_q)
            StIdle: begin
                ack_d = 1'b1;
                if (in_store_bit_i && ack_q) begin
                    sign_d  = in_sign_i;
                    exp_d   = $signed(in_exponent_i);
                    mant_d  = in_mantissa_i;
                    zero_d  = 1'b0;
                    ack_d   = 1'b0;
                    state_d = StNormalize;
                end
            end

            StNormalize: begin
                if (mant_q == 57'd0) begin
                    // Zero skips rounding; the pack step emits +0.
                    zero_d  = 1'b1;
                    state_d = StPack;
                end else if (mant_q[56] || (exp_q < ExpMin)) begin
                    // Right shift, folding the dropped bit into sticky.
                    mant_d = {1'b0, mant_q[56:2], mant_q[1] | mant_q[0]};
                    exp_d  = exp_q + 13'sd1;
                end else if (!mant_q[55] && (exp_q > ExpMin)) begin
                    mant_d = {mant_q[55:0], 1'b0};
                    exp_d  = exp_q - 13'sd1;
                end else begin
                    state_d = StRound;
                end
            end

            StRound: begin
                if (round_up) begin
                    if (rounded[53]) begin
                        // Carry out of the hidden bit: renormalize in the same cycle.
                        mant_d = {1'b0, rounded, 2'b00};
                        exp_d  = exp_q + 13'sd1;
                    end else begin
                        mant_d = {rounded, 3'b000};
                    end
                end
                state_d = StPack;
            end

            StPack: begin
                if (zero_q) begin
                    result_d = 64'h0;
                end else if (exp_q > ExpMax) begin
                    result_d = {sign_q, 11'h7FF, 52'h0};
                end else if ((exp_q == ExpMin) && !mant_q[55]) begin
                    result_d = {sign_q, 11'h000, mant_q[54:3]};
                end else begin
                    result_d = {sign_q, biased_exp, mant_q[54:3]};
                end
                state_d = StOutput;
            end

            StOutput: begin
                if (result_acknowledgment_i) begin
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            zero_q   <= 1'b0;
            ack_q    <= 1'b0;
            result_q <= 64'h0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            zero_q   <= zero_d;
            ack_q    <= ack_d;
            result_q <= result_d;
        end
    end

    assign in_acknowledgment_o = ack_q;
    assign result_store_bit_o  = (state_q == StOutput);
    assign result_o            = result_q;

endmodule

// File: tb/tb_fp_normalize_round_pack.sv
// Scoreboard bench for fp_normalize_round_pack: a driver issues directed
// operands and pushes expected result/latency; a monitor pops and compares
// whenever the DUT presents a result.

module tb_fp_normalize_round_pack;

    logic        clk;
    logic        rst_n;
    logic        in_store_bit;
    logic        in_ack;
    logic        in_sign;
    logic [12:0] in_exponent;
    logic [56:0] in_mantissa;
    logic        res_store_bit;
    logic        res_ack;
    logic [63:0] result;

    fp_normalize_round_pack dut (
        .clk_i                   (clk),
        .rst_ni                  (rst_n),
        .in_store_bit_i          (in_store_bit),
        .in_acknowledgment_o     (in_ack),
        .in_sign_i               (in_sign),
        .in_exponent_i           (in_exponent),
        .in_mantissa_i           (in_mantissa),
        .result_store_bit_o      (res_store_bit),
        .result_acknowledgment_i (res_ack),
        .result_o                (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          lat;
        time         t_acc;
    } exp_t;

    typedef struct {
        logic        sign;
        logic [12:0] exp;
        logic [56:0] mant;
        logic [63:0] res;
        int          lat;
        int          hold;
    } vec_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   ack_delay = 0;
    bit   mon_busy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/unexpected event, required normal completion", name);
    endtask

    // Issue one operand; when push is set, queue the expected response.
    task automatic send(input logic s, input logic [12:0] e, input logic [56:0] m,
                        input logic [63:0] res, input int lat, input bit push);
        exp_t x;
        int   n;
        @(negedge clk);
        in_sign      = s;
        in_exponent  = e;
        in_mantissa  = m;
        in_store_bit = 1'b1;
        n = 0;
        while (!in_ack && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ack) begin
            fail_now("accept_timeout");
            in_store_bit = 1'b0;
            return;
        end
        @(posedge clk);
        x.res   = res;
        x.lat   = lat;
        x.t_acc = $time;
        if (push) sb.push_back(x);
        @(negedge clk);
        in_store_bit = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || mon_busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || mon_busy) fail_now("drain_timeout");
    endtask

    // Monitor: compare on first sight of a valid result, then acknowledge.
    initial begin
        exp_t        x;
        logic [63:0] held;
        int          lat;
        res_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && res_store_bit) begin
                mon_busy = 1'b1;
                if (sb.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    x   = sb.pop_front();
                    lat = int'(($time - x.t_acc - 5) / 10);
                    check("result", result, x.res);
                    check("latency", 64'(lat), 64'(x.lat));
                end
                held = result;
                for (int i = 0; i < ack_delay; i++) begin
                    @(negedge clk);
                    check("hold_store_bit", 64'(res_store_bit), 64'd1);
                    check("hold_result", result, held);
                    check("hold_in_ack", 64'(in_ack), 64'd0);
                end
                res_ack = 1'b1;
                @(negedge clk);
                res_ack = 1'b0;
                check("store_bit_falls", 64'(res_store_bit), 64'd0);
                check("in_ack_still_low", 64'(in_ack), 64'd0);
                @(negedge clk);
                check("in_ack_rises", 64'(in_ack), 64'd1);
                mon_busy = 1'b0;
            end
        end
    end

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b0, 13'd0,    57'h080_0000_0000_0000, 64'h3FF0000000000000, 3,  0};
        vecs[1] = '{1'b0, 13'd0,    57'h100_0000_0000_0000, 64'h4000000000000000, 4,  0};
        vecs[2] = '{1'b0, 13'd0,    57'h000_0000_0000_0008, 64'h3CB0000000000000, 55, 0};
        vecs[3] = '{1'b0, 13'd0,    57'h080_0000_0000_0004, 64'h3FF0000000000000, 3,  0};
        vecs[4] = '{1'b0, 13'd0,    57'h080_0000_0000_000C, 64'h3FF0000000000002, 3,  0};
        vecs[5] = '{1'b0, 13'd0,    57'h080_0000_0000_0006, 64'h3FF0000000000001, 3,  0};
        vecs[6] = '{1'b0, 13'd1023, 57'h0FF_FFFF_FFFF_FFFC, 64'h7FF0000000000000, 3,  0};
        vecs[7] = '{1'b1, 13'd0,    57'h000_0000_0000_0000, 64'h0000000000000000, 2,  0};
        vecs[8] = '{1'b0, 13'h1C01, 57'h080_0000_0000_0000, 64'h0008000000000000, 4,  0};
        vecs[9] = '{1'b1, 13'd1,    57'h080_0000_0000_0000, 64'hC000000000000000, 3,  5};

        rst_n        = 1'b0;
        in_store_bit = 1'b0;
        in_sign      = 1'b0;
        in_exponent  = '0;
        in_mantissa  = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ack", 64'(in_ack), 64'd0);
        check("reset_store_bit", 64'(res_store_bit), 64'd0);
        check("reset_result", result, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ack_after_reset", 64'(in_ack), 64'd1);

        for (int i = 0; i < 10; i++) begin
            drain();
            ack_delay = vecs[i].hold;
            send(vecs[i].sign, vecs[i].exp, vecs[i].mant, vecs[i].res, vecs[i].lat, 1'b1);
        end
        drain();
        ack_delay = 0;

        // Reset during a long normalization: the operand must vanish.
        send(1'b0, 13'd0, 57'h000_0000_0000_0008, 64'h0, 0, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_in_ack", 64'(in_ack), 64'd0);
        check("midreset_store_bit", 64'(res_store_bit), 64'd0);
        check("midreset_result", result, 64'h0);
        rst_n = 1'b1;
        repeat (70) @(negedge clk);
        check("post_reset_in_ack", 64'(in_ack), 64'd1);
        check("post_reset_store_bit", 64'(res_store_bit), 64'd0);

        send(vecs[0].sign, vecs[0].exp, vecs[0].mant, vecs[0].res, vecs[0].lat, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
